multi_debounce: RTL and testbench
=================================

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 Parameter NCH, default 8: number of independent input channels, range 1..32.
REQ-002 Parameter CNT_W, default 16: width of the per-channel stability counter and of thresh.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser flip-flops per channel, range 2..4.
REQ-004 Parameter INIT, default 1'b0: reset value of every synchroniser stage and filtered output.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rstn  input  1  reset, asynchronous, active-high; clock clk.
REQ-007 i  input  NCH  raw asynchronous channel inputs.
REQ-008 en  input  NCH  per-channel enable; quasi-static.
REQ-009 thresh  input  CNT_W  required stable cycles before the output changes; shared by all channels.
REQ-010 ev_clr  input  NCH  write-1-to-clear strobe for the sticky event flags.
REQ-011 o  output  NCH  debounced channel levels.
REQ-012 rise  output  NCH  one-cycle pulse when o[n] goes 0->1.
REQ-013 fall  output  NCH  one-cycle pulse when o[n] goes 1->0.
REQ-014 ev  output  NCH  sticky flag, set by any rise or fall on channel n.
REQ-015 irq  output  1  OR-reduction of ev, registered.

Function
REQ-016 Each channel shall pass i[n] through SYNC_STAGES flip-flops; s[n] denotes the last stage.
REQ-017 Each channel shall own a CNT_W-bit counter cnt[n] and a level register o[n].
REQ-018 Effective threshold T = thresh, except that thresh==0 shall be treated as T=1.
REQ-019 If en[n]=0: cnt[n] <= 0, o[n] held, rise/fall[n]=0; the synchroniser keeps sampling.
REQ-020 If en[n]=1 and s[n]==o[n]: cnt[n] <= 0 (any partial count discarded).
REQ-021 If en[n]=1, s[n]!=o[n], cnt[n]==T-1: o[n] <= s[n], cnt[n] <= 0, and the matching rise/fall[n] shall be 1 in the same cycle o[n] first shows the new value.
REQ-022 If en[n]=1, s[n]!=o[n], cnt[n]<T-1: cnt[n] <= cnt[n]+1.
REQ-023 Latency: a level on i held steady from edge k shall appear on o after SYNC_STAGES+T edges; a deviation of s lasting fewer than T cycles shall produce no change on o.
REQ-024 cnt[n] shall never exceed T-1; if thresh is lowered mid-count so that cnt[n]>=T-1, the next deviating cycle shall commit the change (compare uses >=).
REQ-025 rise and fall shall be registered, never both 1 on one channel, and deasserted the following cycle unless a new commit occurs.
REQ-026 ev[n] shall set on rise[n]|fall[n]; ev_clr[n]=1 clears it; simultaneous set and clear shall leave ev[n]=1.
REQ-027 irq shall equal the OR of ev one cycle later.
REQ-028 Channels shall be fully independent; no channel's state shall affect another.

Reset
REQ-029 While rstn=1, asynchronously: synchronisers and o = {NCH{INIT}}, cnt=0, rise=fall=0, ev=0, irq=0.
REQ-030 Reset asserted mid-count shall discard the count; after release, counting restarts from 0 against o=INIT.
REQ-031 Release of rstn shall be synchronised externally; the block adds no reset synchroniser.

Verification
REQ-032 NCH=4, CNT_W=8, SYNC_STAGES=2, INIT=0, thresh=4: i[0] 0->1 steady -> o[0]=1 and rise[0]=1 exactly 6 edges later, ev[0]=1 next cycle, irq=1 the cycle after.
REQ-033 thresh=4, i[1] high for 3 cycles then low -> o[1], rise[1], ev[1] stay 0; i[1] high for 4 cycles -> o[1] rises and falls, one rise and one fall pulse.
REQ-034 thresh=0 -> behaves as T=1: o[2] follows i[2] 3 edges later, including single-cycle pulses.
REQ-035 en[3]=0 while i[3] toggles, then en[3]=1 with i[3]=1 -> no change while disabled; o[3] rises 4 edges after enable.
REQ-036 ev[0]=1 set by rise and ev_clr[0]=1 in the same cycle as a fall commit -> ev[0] stays 1; ev_clr alone next cycle -> ev[0]=0, irq=0 one cycle later.
REQ-037 rstn=1 asserted when cnt[0]=2 -> all outputs INIT/0 immediately; after release a new 4-cycle deviation is required to change o[0].

Source files
------------

// File: rtl/multi_debounce.sv
// Multi-channel debouncer: per-channel synchroniser, stability counter and
// registered level / edge / sticky-event outputs with a shared threshold.
module multi_debounce #(
  parameter int unsigned NCH         = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        INIT        = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NCH-1:0]   i,
  input  logic [NCH-1:0]   en,
  input  logic [CNT_W-1:0] thresh,
  input  logic [NCH-1:0]   ev_clr,
  output logic [NCH-1:0]   o,
  output logic [NCH-1:0]   rise,
  output logic [NCH-1:0]   fall,
  output logic [NCH-1:0]   ev,
  output logic             irq
);

  logic [NCH-1:0]   sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q  [NCH];
  logic [NCH-1:0]   s;
  logic [CNT_W-1:0] tm1;

  assign s = sync_q[SYNC_STAGES-1];
  // A zero threshold behaves as one, so the terminal count is 0 in both cases.
  assign tm1 = (thresh == '0) ? '0 : thresh - CNT_W'(1);

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= {NCH{INIT}};
      end
      for (int n = 0; n < NCH; n++) begin
        cnt_q[n] <= '0;
      end
      o    <= {NCH{INIT}};
      rise <= '0;
      fall <= '0;
      ev   <= '0;
      irq  <= 1'b0;
    end else begin
      sync_q[0] <= i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      for (int n = 0; n < NCH; n++) begin
        rise[n] <= 1'b0;
        fall[n] <= 1'b0;
        if (!en[n] || (s[n] == o[n])) begin
          cnt_q[n] <= '0;
        end else if (cnt_q[n] >= tm1) begin
          // >= so a threshold lowered mid-count commits on the next deviation.
          o[n]     <= s[n];
          cnt_q[n] <= '0;
          rise[n]  <= s[n];
          fall[n]  <= ~s[n];
        end else begin
          cnt_q[n] <= cnt_q[n] + CNT_W'(1);
        end
      end
      // Set has priority over a simultaneous clear.
      ev  <= (ev & ~ev_clr) | rise | fall;
      irq <= |ev;
    end
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce with NCH=4, CNT_W=8, SYNC_STAGES=2, INIT=0.
module tb_multi_debounce;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] i;
  logic [3:0] en;
  logic [7:0] thresh;
  logic [3:0] ev_clr;
  logic [3:0] o;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] ev;
  logic       irq;

  int n_vec = 0;
  int n_err = 0;

  multi_debounce #(
    .NCH        (4),
    .CNT_W      (8),
    .SYNC_STAGES(2),
    .INIT       (1'b0)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .i     (i),
    .en    (en),
    .thresh(thresh),
    .ev_clr(ev_clr),
    .o     (o),
    .rise  (rise),
    .fall  (fall),
    .ev    (ev),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #1 rstn = 1'b1;
    #1;
    n_vec++;
    if ({o, rise, fall, ev, irq} !== 17'h0) begin
      $display("FAIL reset_state: got %h required %h", {o, rise, fall, ev, irq}, 17'h0);
      n_err++;
    end
    tick();
    tick();
    rstn = 1'b0;
  endtask

  task automatic test_latency();
    i[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_vec++;
      if (o[0] !== 1'b0) begin
        $display("FAIL latency_early edge %0d: o0 got %b required 0", k, o[0]);
        n_err++;
      end
    end
    tick();
    n_vec++;
    if ({o[0], rise[0], ev[0]} !== 3'b110) begin
      $display("FAIL latency_commit: o0/rise0/ev0 got %b required 110", {o[0], rise[0], ev[0]});
      n_err++;
    end
    tick();
    n_vec++;
    if ({rise[0], ev[0], irq} !== 3'b010) begin
      $display("FAIL latency_ev: rise0/ev0/irq got %b required 010", {rise[0], ev[0], irq});
      n_err++;
    end
    tick();
    n_vec++;
    if (irq !== 1'b1) begin
      $display("FAIL latency_irq: got %b required 1", irq);
      n_err++;
    end
  endtask

  task automatic test_glitch();
    int nr = 0;
    int nf = 0;
    i[1] = 1'b1;
    repeat (3) tick();
    i[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_vec++;
      if ({o[1], rise[1], ev[1]} !== 3'b000) begin
        $display("FAIL glitch_short cycle %0d: o1/rise1/ev1 got %b required 000", k,
                 {o[1], rise[1], ev[1]});
        n_err++;
      end
    end
    i[1] = 1'b1;
    repeat (4) tick();
    i[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (rise[1]) nr++;
      if (fall[1]) nf++;
      n_vec++;
      if (rise[1] && fall[1]) begin
        $display("FAIL glitch_both cycle %0d: rise1/fall1 got 11 required not both", k);
        n_err++;
      end
    end
    n_vec++;
    if (nr != 1 || nf != 1 || o[1] !== 1'b0) begin
      $display("FAIL glitch_pulses: rise/fall/o1 got %0d/%0d/%b required 1/1/0", nr, nf, o[1]);
      n_err++;
    end
  endtask

  task automatic test_thresh_zero();
    thresh = 8'd0;
    i[2] = 1'b1;
    tick();
    i[2] = 1'b0;
    tick();
    n_vec++;
    if (o[2] !== 1'b0) begin
      $display("FAIL t0_early: o2 got %b required 0", o[2]);
      n_err++;
    end
    tick();
    n_vec++;
    if ({o[2], rise[2], fall[2]} !== 3'b110) begin
      $display("FAIL t0_rise: o2/rise2/fall2 got %b required 110", {o[2], rise[2], fall[2]});
      n_err++;
    end
    tick();
    n_vec++;
    if ({o[2], rise[2], fall[2]} !== 3'b001) begin
      $display("FAIL t0_fall: o2/rise2/fall2 got %b required 001", {o[2], rise[2], fall[2]});
      n_err++;
    end
    thresh = 8'd4;
    tick();
  endtask

  task automatic test_enable();
    for (int k = 0; k < 6; k++) begin
      i[3] = ~i[3];
      tick();
      n_vec++;
      if ({o[3], rise[3]} !== 2'b00) begin
        $display("FAIL en_off cycle %0d: o3/rise3 got %b required 00", k, {o[3], rise[3]});
        n_err++;
      end
    end
    i[3] = 1'b1;
    repeat (3) tick();
    en[3] = 1'b1;
    repeat (3) tick();
    n_vec++;
    if (o[3] !== 1'b0) begin
      $display("FAIL en_early: o3 got %b required 0", o[3]);
      n_err++;
    end
    tick();
    n_vec++;
    if ({o[3], rise[3]} !== 2'b11) begin
      $display("FAIL en_commit: o3/rise3 got %b required 11", {o[3], rise[3]});
      n_err++;
    end
    tick();
    n_vec++;
    if (ev[3] !== 1'b1) begin
      $display("FAIL en_ev: ev3 got %b required 1", ev[3]);
      n_err++;
    end
  endtask

  task automatic test_ev_clr();
    ev_clr = 4'b1110;
    tick();
    ev_clr = 4'b0000;
    n_vec++;
    if (ev !== 4'b0001) begin
      $display("FAIL evclr_others: ev got %b required 0001", ev);
      n_err++;
    end
    i[0] = 1'b0;
    repeat (6) tick();
    n_vec++;
    if ({o[0], fall[0]} !== 2'b01) begin
      $display("FAIL evclr_fall: o0/fall0 got %b required 01", {o[0], fall[0]});
      n_err++;
    end
    ev_clr = 4'b0001;
    tick();
    n_vec++;
    if (ev[0] !== 1'b1) begin
      $display("FAIL evclr_set_wins: ev0 got %b required 1", ev[0]);
      n_err++;
    end
    tick();
    ev_clr = 4'b0000;
    n_vec++;
    if ({ev, irq} !== 5'b00001) begin
      $display("FAIL evclr_clear: ev/irq got %b required 00001", {ev, irq});
      n_err++;
    end
    tick();
    n_vec++;
    if (irq !== 1'b0) begin
      $display("FAIL evclr_irq: got %b required 0", irq);
      n_err++;
    end
  endtask

  task automatic test_reset_midcount();
    i[0] = 1'b1;
    repeat (4) tick();
    rstn = 1'b1;
    #1;
    n_vec++;
    if ({o, rise, fall, ev, irq} !== 17'h0) begin
      $display("FAIL rst_async: got %h required %h", {o, rise, fall, ev, irq}, 17'h0);
      n_err++;
    end
    @(negedge clk);
    rstn = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_vec++;
      if (o !== 4'b0000) begin
        $display("FAIL rst_recount edge %0d: o got %b required 0000", k, o);
        n_err++;
      end
    end
    tick();
    n_vec++;
    if ({o, rise} !== 8'b1001_1001) begin
      $display("FAIL rst_commit: o/rise got %b required 10011001", {o, rise});
      n_err++;
    end
  endtask

  initial begin
    i      = 4'b0000;
    en     = 4'b0111;
    thresh = 8'd4;
    ev_clr = 4'b0000;
    test_reset();
    test_latency();
    test_glitch();
    test_thresh_zero();
    test_enable();
    test_ev_clr();
    test_reset_midcount();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
